// File: rtl/calc_lut_scheduler_if.sv
// Requester/consumer bus for calc_lut_scheduler: two lookup request channels
// and the valid/ready response channel.
interface calc_lut_scheduler_if;
    logic       req_a;
    logic       req_b;
    logic [3:0] code_a;
    logic [3:0] code_b;
    logic       gnt_a;
    logic       gnt_b;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [9:0] rsp_data;
    logic [3:0] rsp_code;
    logic [1:0] rsp_src;

    modport master (
        output req_a, req_b, code_a, code_b, rsp_ready,
        input  gnt_a, gnt_b, rsp_valid, rsp_data, rsp_code, rsp_src
    );

    modport slave (
        input  req_a, req_b, code_a, code_b, rsp_ready,
        output gnt_a, gnt_b, rsp_valid, rsp_data, rsp_code, rsp_src
    );
endinterface

// File: rtl/calc_lut_scheduler.sv
// Round-robin scheduler sharing one combinational digit lookup between two requesters.
// Optional self-test sweep of all 16 codes when built with SCAN_EN defined.
module calc_lut_scheduler #(
    parameter int SETTLE_CYCLES = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    calc_lut_scheduler_if.slave  bus,
    output logic [3:0]           lut_in,
    input  logic [9:0]           lut_out,
    output logic                 busy,
    input  logic                 scan_start
);

    // state  | meaning
    // IDLE   | waiting for a request or scan start; only state that grants
    // SETTLE | lut_in held while the lookup settles (down-counter to zero)
    // RESP   | response presented, waiting for rsp_ready
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam logic [1:0] SRC_A    = 2'b00;
    localparam logic [1:0] SRC_B    = 2'b01;
    localparam logic [1:0] SRC_SCAN = 2'b10;
    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

    state_t     state_q, state_d;
    logic [3:0] cnt_q;
    logic [1:0] src_q;
    logic       prio_b_q;
    logic       scan_active_q;
    logic [3:0] scan_idx_q;
    logic       gnt_a_q, gnt_b_q;
    logic       rsp_valid_q;
    logic [9:0] rsp_data_q;
    logic [3:0] rsp_code_q;
    logic [1:0] rsp_src_q;

    logic take_a, take_b, take_scan;
    logic settle_done, rsp_done, scan_next;
    logic scan_go;

`ifdef SCAN_EN
    assign scan_go = scan_start;
`else
    logic unused_scan_start;
    assign unused_scan_start = scan_start;
    assign scan_go = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        take_a      = 1'b0;
        take_b      = 1'b0;
        take_scan   = 1'b0;
        settle_done = 1'b0;
        rsp_done    = 1'b0;
        scan_next   = 1'b0;
        case (state_q)
            IDLE: begin
                if (scan_go) begin
                    take_scan = 1'b1;
                    state_d   = SETTLE;
                end else if (bus.req_a && (!bus.req_b || !prio_b_q)) begin
                    take_a  = 1'b1;
                    state_d = SETTLE;
                end else if (bus.req_b) begin
                    take_b  = 1'b1;
                    state_d = SETTLE;
                end
            end
            SETTLE: begin
                if (cnt_q == 4'd0) begin
                    settle_done = 1'b1;
                    state_d     = RESP;
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    rsp_done = 1'b1;
                    // a sweep chains straight into the next code so busy never drops
                    if (scan_active_q && (scan_idx_q != 4'hF)) begin
                        scan_next = 1'b1;
                        state_d   = SETTLE;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            cnt_q         <= 4'd0;
            src_q         <= SRC_A;
            prio_b_q      <= 1'b0;
            scan_active_q <= 1'b0;
            scan_idx_q    <= 4'd0;
            gnt_a_q       <= 1'b0;
            gnt_b_q       <= 1'b0;
            lut_in        <= 4'd0;
            rsp_valid_q   <= 1'b0;
            rsp_data_q    <= 10'd0;
            rsp_code_q    <= 4'd0;
            rsp_src_q     <= 2'b00;
        end else begin
            state_q <= state_d;
            gnt_a_q <= take_a;
            gnt_b_q <= take_b;

            if (take_a || take_b || take_scan || scan_next) begin
                cnt_q <= SETTLE_LOAD;
            end else if ((state_q == SETTLE) && (cnt_q != 4'd0)) begin
                cnt_q <= cnt_q - 4'd1;
            end

            if (take_a) begin
                lut_in   <= bus.code_a;
                src_q    <= SRC_A;
                prio_b_q <= 1'b1;
            end
            if (take_b) begin
                lut_in   <= bus.code_b;
                src_q    <= SRC_B;
                prio_b_q <= 1'b0;
            end
            if (take_scan) begin
                lut_in        <= 4'd0;
                src_q         <= SRC_SCAN;
                scan_active_q <= 1'b1;
                scan_idx_q    <= 4'd0;
            end
            if (scan_next) begin
                scan_idx_q <= scan_idx_q + 4'd1;
                lut_in     <= scan_idx_q + 4'd1;
            end

            if (settle_done) begin
                rsp_valid_q <= 1'b1;
                rsp_data_q  <= lut_out;
                rsp_code_q  <= lut_in;
                rsp_src_q   <= src_q;
            end
            if (rsp_done) begin
                rsp_valid_q <= 1'b0;
                if (!scan_next) begin
                    scan_active_q <= 1'b0;
                    scan_idx_q    <= 4'd0;
                end
            end
        end
    end

    assign busy          = (state_q != IDLE);
    assign bus.gnt_a     = gnt_a_q;
    assign bus.gnt_b     = gnt_b_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_code  = rsp_code_q;
    assign bus.rsp_src   = rsp_src_q;

endmodule

// File: doc/calc_lut_scheduler.md
CALC_LUT_SCHEDULER -- requirements
Module: calc_lut_scheduler

Interface
REQ-001 SHALL have parameter: SETTLE_CYCLES, default 1, cycles lut_in is held before lut_out is sampled; legal range 1..15.
REQ-002 SHALL have port: clk  in  1  sole clock, rising edge.
REQ-003 SHALL have port: rst  in  1  reset, asynchronous, active-high.
REQ-004 SHALL have ports: req_a/req_b  in  1 each  lookup request from requester A/B.
REQ-005 SHALL have ports: code_a/code_b  in  4 each  4-bit operand code; bit3=w (MSB) .. bit0=z.
REQ-006 SHALL have ports: gnt_a/gnt_b  out  1 each  one-cycle accept pulse.
REQ-007 SHALL have port: lut_in  out  4  code driven to the shared combinational digit lookup.
REQ-008 SHALL have port: lut_out  in  10  lookup result; bit n = rn.
REQ-009 SHALL have ports: rsp_valid out 1, rsp_ready in 1, rsp_data out 10, rsp_code out 4, rsp_src out 2 (00=A, 01=B, 10=scan).
REQ-010 SHALL have port: busy  out  1  high whenever the FSM is not IDLE.
REQ-011 SHALL have port: scan_start  in  1  self-test sweep request; present in all builds.

Function
REQ-012 FSM SHALL have states IDLE, SETTLE and RESP, and no others.
REQ-013 IDLE: at any edge with a request pending, SHALL grant one requester, latch its code into lut_in, pulse its gnt for exactly one cycle, load the settle counter and enter SETTLE.
REQ-014 Arbitration SHALL be round-robin over A/B: on simultaneous requests, the requester not served last wins; A wins first after reset.
REQ-015 A single requester SHALL be granted on consecutive transactions when the other is idle.
REQ-016 SETTLE SHALL last exactly SETTLE_CYCLES cycles; on its final edge, rsp_data<=lut_out, rsp_code<=lut_in, rsp_src set, rsp_valid<=1, enter RESP.
REQ-017 Latency: gnt high in cycle G SHALL give rsp_valid first high in cycle G+SETTLE_CYCLES.
REQ-018 RESP: rsp_valid, rsp_data, rsp_code and rsp_src SHALL remain stable until an edge with rsp_ready=1; at that edge rsp_valid<=0 and state SHALL become IDLE.
REQ-019 rsp_ready already high on entering RESP SHALL complete the handshake after one cycle; a new grant SHALL be possible on the next edge (IDLE dwell of one cycle).
REQ-020 No gnt SHALL assert outside IDLE; requests arriving during a transaction SHALL wait and not be lost while held.
REQ-021 A requester dropping req before its grant SHALL receive no gnt.
REQ-022 Requesters SHALL hold the code stable while req=1; the code is sampled only on the grant edge.
REQ-023 lut_in SHALL hold its last code after completion and change only on a grant or scan step.

Reset
REQ-024 rst=1 SHALL immediately force: state IDLE, lut_in=0, rsp_valid=0, rsp_data=0, rsp_code=0, rsp_src=0, gnt_a=gnt_b=0, busy=0, round-robin pointer to A priority, and scan index to 0.
REQ-025 Reset mid-transaction SHALL drop the in-flight lookup with no rsp_valid produced.

Configuration
REQ-026 With SCAN_EN defined: scan_start=1 in IDLE SHALL take priority over req_a/req_b and sequence codes 0..15 as 16 back-to-back transactions (rsp_src=10, rsp_code=index, no gnt pulses), each completing via the rsp handshake; busy SHALL stay high across the whole sweep; return to IDLE after code 15 is accepted.
REQ-027 Without SCAN_EN: scan_start SHALL be ignored and rsp_src SHALL never equal 10.

Verification
REQ-028 Reset, then req_a=1, code_a=4'h5, rsp_ready=1, bench lookup model returning 10'h2A5 -> gnt_a one cycle; rsp_valid 1 cycle later (SETTLE_CYCLES=1) with rsp_data=10'h2A5, rsp_code=5, rsp_src=00.
REQ-029 req_a and req_b high together for 4 transactions, codes 3 and 12 -> grants alternate A,B,A,B; rsp_code alternates 3,12.
REQ-030 rsp_ready=0 for 7 cycles in RESP while req_b toggles -> outputs stable; no gnt_b until the cycle after the handshake.
REQ-031 rst asserted during SETTLE with SETTLE_CYCLES=4 -> all outputs 0 at once; no rsp_valid; next req_b and req_a together grants A first.
REQ-032 SCAN_EN build, scan_start pulse with req_a held -> 16 responses, rsp_code 0..15, rsp_src=10, rsp_data matching the model; then gnt_a.
REQ-033 Non-SCAN_EN build, scan_start=1 -> no response; busy stays 0.
